// File: rtl/lcd_dma_bridge_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lcd_dma_bridge_if
// Description : Avalon-MM write-only handshake between the frame-buffer DMA
//               (master) and the LCD DMA bridge (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_dma_bridge_if;
  logic       chipselect;   // DMA slave select
  logic       write_n;      // write strobe, active low
  logic [7:0] writedata;    // pixel byte
  logic       waitrequest;  // slave back-pressure (FIFO full)

  modport master (
    output chipselect,
    output write_n,
    output writedata,
    input  waitrequest
  );

  modport slave (
    input  chipselect,
    input  write_n,
    input  writedata,
    output waitrequest
  );
endinterface
`default_nettype wire

// File: rtl/lcd_dma_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lcd_dma_bridge
// Description : Avalon-MM write-only slave that buffers DMA pixel bytes in a
//               small FIFO and plays them out on a parallel LCD bus at a
//               divided rate. Page/column address commands are inserted at
//               every page boundary; the position wraps at end of frame.
//               While the engine is idle and the DMA is deselected, the LCD
//               bus is handed to the CPU pins.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_dma_bridge #(
  parameter int CLK_DIV    = 32,   // clocks per bus phase (>= 2)
  parameter int COLS       = 128,  // data bytes per page
  parameter int PAGES      = 8,    // pages per frame
  parameter int COL_OFFSET = 4,    // first column address of every page
  parameter int FIFO_DEPTH = 4     // byte buffer entries (power of 2, >= 2)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [4:0]            i_LCD_Control_CPU,
  input  logic [7:0]            i_LCD_Data_CPU,
  lcd_dma_bridge_if.slave       dma,
  input  logic                  i_frame_restart,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic [4:0]            o_LCD_Control,
  output logic [7:0]            o_LCD_Data
);

  // --------------------------------------------------------------------------
  // Derived widths and constants
  // --------------------------------------------------------------------------
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int COL_W  = (COLS  > 1) ? $clog2(COLS)  : 1;
  localparam int PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1;

  localparam logic [CNT_W-1:0]  C_FULL       = CNT_W'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0]  C_DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [COL_W-1:0]  C_COL_LAST   = COL_W'(COLS - 1);
  localparam logic [PAGE_W-1:0] C_PAGE_LAST  = PAGE_W'(PAGES - 1);
  localparam logic [7:0]        C_COL_OFF    = 8'(COL_OFFSET);
  localparam logic [7:0]        C_CMD_PAGE   = 8'hB0;
  localparam logic [7:0]        C_CMD_COLH   = 8'h10 | {4'h0, C_COL_OFF[7:4]};
  localparam logic [7:0]        C_CMD_COLL   = {4'h0, C_COL_OFF[3:0]};
  localparam logic [4:0]        C_CTRL_RESET = 5'b00011;

  // Bus phase within one LCD bus cycle
  localparam logic PH_HI = 1'b0;
  localparam logic PH_LO = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CMD_PAGE = 3'd1,
    ST_CMD_COLH = 3'd2,
    ST_CMD_COLL = 3'd3,
    ST_DATA     = 3'd4
  } state_e;

  // Control word {E,RW,A0,RST,CS} for the strobe-high and strobe-low phases
  function automatic logic [4:0] f_ctrl_hi(input logic a0);
    return {1'b1, 1'b0, a0, 1'b1, 1'b0};
  endfunction

  function automatic logic [4:0] f_ctrl_lo(input logic a0);
    return {1'b0, 1'b0, a0, 1'b1, 1'b1};
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e              state_q,        state_d;
  logic                phase_q,        phase_d;
  logic [DIV_W-1:0]    div_q,          div_d;
  logic [PAGE_W-1:0]   page_q,         page_d;
  logic [COL_W-1:0]    col_q,          col_d;
  logic                restart_pend_q, restart_pend_d;
  logic [4:0]          ctrl_q,         ctrl_d;
  logic [7:0]          data_q,         data_d;
  logic                frame_done_q,   frame_done_d;
  logic [PTR_W-1:0]    wr_ptr_q,       wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q,       rd_ptr_d;
  logic [CNT_W-1:0]    count_q,        count_d;
  logic [7:0]          mem_q [FIFO_DEPTH];

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_tick;
  logic                w_enter;
  logic                w_restart;

  // Full/empty come straight from the registered count, so a pop in the
  // same cycle as a full-FIFO write never admits that write.
  assign w_full           = (count_q == C_FULL);
  assign w_empty          = (count_q == '0);
  assign w_push           = dma.chipselect & ~dma.write_n & ~w_full;
  assign w_tick           = (div_q == C_DIV_LAST);
  assign w_restart        = i_frame_restart | restart_pend_q;

  assign dma.waitrequest  = w_full;
  assign o_busy           = (state_q != ST_IDLE) | ~w_empty;
  assign o_frame_done     = frame_done_q;
  assign o_LCD_Control    = ctrl_q;
  assign o_LCD_Data       = data_q;

  // FIFO pointer and occupancy bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
  end

  // Bus engine: next state, page/column tracking and next bus outputs
  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    page_d         = page_q;
    col_d          = col_q;
    restart_pend_d = restart_pend_q | i_frame_restart;
    ctrl_d         = ctrl_q;
    data_d         = data_q;
    frame_done_d   = 1'b0;
    w_enter        = 1'b0;
    w_pop          = 1'b0;

    // Phase divider only runs while a bus cycle is in progress
    if ((state_q == ST_IDLE) || w_tick) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        // A restart seen while idle is already at a byte boundary
        if (w_restart) begin
          page_d         = '0;
          col_d          = '0;
          restart_pend_d = 1'b0;
        end
        if (!w_empty) begin
          w_enter = 1'b1;
          state_d = (w_restart || (col_q == '0)) ? ST_CMD_PAGE : ST_DATA;
        end else if (!dma.chipselect) begin
          // CPU owns the bus; the next DMA stream starts at the top of frame
          ctrl_d         = i_LCD_Control_CPU;
          data_d         = i_LCD_Data_CPU;
          page_d         = '0;
          col_d          = '0;
          restart_pend_d = 1'b0;
        end
      end

      default: begin
        if (w_tick) begin
          if (phase_q == PH_HI) begin
            // Drop the strobe; data stays on the bus through the LO phase
            phase_d = PH_LO;
            ctrl_d  = f_ctrl_lo(state_q == ST_DATA);
          end else begin
            case (state_q)
              ST_CMD_PAGE: state_d = ST_CMD_COLH;
              ST_CMD_COLH: state_d = ST_CMD_COLL;
              ST_CMD_COLL: state_d = w_empty ? ST_IDLE : ST_DATA;
              default: begin
                // Data byte finished: advance the frame position
                if (col_q == C_COL_LAST) begin
                  col_d = '0;
                  if (page_q == C_PAGE_LAST) begin
                    page_d       = '0;
                    frame_done_d = 1'b1;
                  end else begin
                    page_d = page_q + PAGE_W'(1);
                  end
                end else begin
                  col_d = col_q + COL_W'(1);
                end
                if (w_restart) begin
                  page_d         = '0;
                  col_d          = '0;
                  restart_pend_d = 1'b0;
                end
                if (w_empty) begin
                  state_d = ST_IDLE;
                end else if (col_d == '0) begin
                  state_d = ST_CMD_PAGE;
                end else begin
                  state_d = ST_DATA;
                end
              end
            endcase
            w_enter = (state_d != ST_IDLE);
          end
        end
      end
    endcase

    // Starting a new bus cycle: raise the strobe with the new byte and,
    // for data, consume the FIFO head on this same edge.
    if (w_enter) begin
      phase_d = PH_HI;
      ctrl_d  = f_ctrl_hi(state_d == ST_DATA);
      case (state_d)
        ST_CMD_PAGE: data_d = C_CMD_PAGE | 8'(page_d);
        ST_CMD_COLH: data_d = C_CMD_COLH;
        ST_CMD_COLL: data_d = C_CMD_COLL;
        default: begin
          data_d = mem_q[rd_ptr_q];
          w_pop  = 1'b1;
        end
      endcase
    end
  end

  // Control and datapath registers; reset aborts any transfer at once
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= ST_IDLE;
      phase_q        <= PH_HI;
      div_q          <= '0;
      page_q         <= '0;
      col_q          <= '0;
      restart_pend_q <= 1'b0;
      ctrl_q         <= C_CTRL_RESET;
      data_q         <= 8'h00;
      frame_done_q   <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      div_q          <= div_d;
      page_q         <= page_d;
      col_q          <= col_d;
      restart_pend_q <= restart_pend_d;
      ctrl_q         <= ctrl_d;
      data_q         <= data_d;
      frame_done_q   <= frame_done_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= dma.writedata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_dma_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lcd_dma_bridge
// Description : Directed bench for lcd_dma_bridge: CPU pass-through table,
//               cycle-exact single-byte timing table, FIFO back-pressure,
//               page/frame wrap, frame restart and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_dma_bridge;
  localparam int CLK_DIV    = 4;
  localparam int COLS       = 4;
  localparam int PAGES      = 2;
  localparam int COL_OFFSET = 4;
  localparam int FIFO_DEPTH = 4;

  typedef struct {
    logic [4:0] cin;
    logic [7:0] din;
    logic [4:0] cexp;
    logic [7:0] dexp;
  } cpu_vec_t;

  typedef struct {
    int         cyc;
    logic [4:0] ctrl;
    logic [7:0] data;
    logic       busy;
  } tim_vec_t;

  typedef struct {
    logic [8:0] b;     // {A0, byte}
    int         len;   // clocks with E high
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] cpu_ctrl = '0;
  logic [7:0] cpu_data = '0;
  logic       frame_restart = 1'b0;
  logic       busy;
  logic       frame_done;
  logic [4:0] lcd_ctrl;
  logic [7:0] lcd_data;

  lcd_dma_bridge_if dma_if ();

  always #5 clk = ~clk;

  lcd_dma_bridge #(
    .CLK_DIV    (CLK_DIV),
    .COLS       (COLS),
    .PAGES      (PAGES),
    .COL_OFFSET (COL_OFFSET),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_LCD_Control_CPU (cpu_ctrl),
    .i_LCD_Data_CPU    (cpu_data),
    .dma               (dma_if),
    .i_frame_restart   (frame_restart),
    .o_busy            (busy),
    .o_frame_done      (frame_done),
    .o_LCD_Control     (lcd_ctrl),
    .o_LCD_Data        (lcd_data)
  );

  int         checks = 0;
  int         errors = 0;
  int         last_wait = 0;
  logic       mon_en = 1'b0;
  logic       prev_e = 1'b0;
  int         hi_len = 0;
  logic [8:0] hi_byte = '0;
  int         fd_count = 0;
  ev_t        cap[$];
  logic [8:0] exp_q[$];

  // Bus monitor: records every strobe pulse with its byte and width
  always @(negedge clk) begin
    if (frame_done) fd_count <= fd_count + 1;
    if (mon_en && lcd_ctrl[4]) begin
      if (!prev_e) begin
        hi_len  <= 1;
        hi_byte <= {lcd_ctrl[2], lcd_data};
      end else begin
        hi_len <= hi_len + 1;
      end
    end
    if (mon_en && !lcd_ctrl[4] && prev_e) cap.push_back('{b: hi_byte, len: hi_len});
    prev_e <= mon_en & lcd_ctrl[4];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    int w = 0;
    dma_if.write_n   = 1'b0;
    dma_if.writedata = b;
    while (dma_if.waitrequest && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (dma_if.waitrequest) begin
      checks++;
      errors++;
      $display("FAIL push %0h timeout: waitrequest=1 expected 0", b);
    end
    @(posedge clk); #1;
    dma_if.write_n = 1'b1;
    last_wait = w;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s idle timeout: busy=%b expected 0", name, busy);
    end
  endtask

  task automatic cpu_own();
    @(negedge clk);
    dma_if.chipselect = 1'b0;
    dma_if.write_n    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string name, input int base);
    chk($sformatf("%s count", name), 32'(cap.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < cap.size()) begin
        chk($sformatf("%s byte%0d", name, i), 32'(cap[base + i].b), 32'(exp_q[i]));
        chk($sformatf("%s elen%0d", name, i), 32'(cap[base + i].len), 32'(CLK_DIV));
      end
    end
  endtask

  initial begin
    cpu_vec_t cpu_tbl[4];
    tim_vec_t tim_tbl[13];
    int       base;
    int       fd_base;

    cpu_tbl[0] = '{5'h15, 8'hA5, 5'h15, 8'hA5};
    cpu_tbl[1] = '{5'h00, 8'h00, 5'h00, 8'h00};
    cpu_tbl[2] = '{5'h1F, 8'hFF, 5'h1F, 8'hFF};
    cpu_tbl[3] = '{5'h0A, 8'h5A, 5'h0A, 8'h5A};

    // Single byte 3C from page 0 column 0, CLK_DIV=4; cycle 0 is the push edge
    tim_tbl[0]  = '{1,  5'b10010, 8'hB0, 1'b1};
    tim_tbl[1]  = '{4,  5'b10010, 8'hB0, 1'b1};
    tim_tbl[2]  = '{5,  5'b00011, 8'hB0, 1'b1};
    tim_tbl[3]  = '{8,  5'b00011, 8'hB0, 1'b1};
    tim_tbl[4]  = '{9,  5'b10010, 8'h10, 1'b1};
    tim_tbl[5]  = '{13, 5'b00011, 8'h10, 1'b1};
    tim_tbl[6]  = '{17, 5'b10010, 8'h04, 1'b1};
    tim_tbl[7]  = '{21, 5'b00011, 8'h04, 1'b1};
    tim_tbl[8]  = '{25, 5'b10110, 8'h3C, 1'b1};
    tim_tbl[9]  = '{29, 5'b00111, 8'h3C, 1'b1};
    tim_tbl[10] = '{32, 5'b00111, 8'h3C, 1'b1};
    tim_tbl[11] = '{33, 5'b00111, 8'h3C, 1'b0};
    tim_tbl[12] = '{34, 5'b01010, 8'h5A, 1'b0};

    dma_if.chipselect = 1'b0;
    dma_if.write_n    = 1'b1;
    dma_if.writedata  = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset ctrl", 32'(lcd_ctrl), 32'h03);
    chk("reset data", 32'(lcd_data), 32'h00);
    chk("reset waitrequest", 32'(dma_if.waitrequest), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset frame_done", 32'(frame_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // CPU pass-through while idle and deselected
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cpu_ctrl = cpu_tbl[i].cin;
      cpu_data = cpu_tbl[i].din;
      @(posedge clk); #1;
      chk($sformatf("cpu ctrl vec%0d", i), 32'(lcd_ctrl), 32'(cpu_tbl[i].cexp));
      chk($sformatf("cpu data vec%0d", i), 32'(lcd_data), 32'(cpu_tbl[i].dexp));
    end

    // Cycle-exact single byte with command preamble
    cpu_own();
    mon_en = 1'b1;
    base = cap.size();
    @(negedge clk);
    dma_if.chipselect = 1'b1;
    dma_if.write_n    = 1'b0;
    dma_if.writedata  = 8'h3C;
    @(posedge clk); #1;
    dma_if.chipselect = 1'b0;
    dma_if.write_n    = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk); #1;
      for (int j = 0; j < 13; j++) begin
        if (tim_tbl[j].cyc == k) begin
          chk($sformatf("timing ctrl c%0d", k), 32'(lcd_ctrl), 32'(tim_tbl[j].ctrl));
          chk($sformatf("timing data c%0d", k), 32'(lcd_data), 32'(tim_tbl[j].data));
          chk($sformatf("timing busy c%0d", k), 32'(busy), 32'(tim_tbl[j].busy));
        end
      end
    end
    exp_q = {9'h0B0, 9'h010, 9'h004, 9'h13C};
    check_stream("single", base);

    // Back-pressure: five back-to-back writes into a four-entry FIFO
    cpu_own();
    base = cap.size();
    @(negedge clk);
    dma_if.chipselect = 1'b1;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    chk("waitrequest when full", 32'(dma_if.waitrequest), 32'h1);
    push(8'h55);
    chk("stall cycles on 5th write", 32'(last_wait), 32'(6 * CLK_DIV - 2));
    wait_idle("backpressure");
    chk("hold ctrl idle cs=1", 32'(lcd_ctrl), 32'h07);
    chk("hold data idle cs=1", 32'(lcd_data), 32'h55);
    exp_q = {9'h0B0, 9'h010, 9'h004, 9'h111, 9'h122, 9'h133, 9'h144,
             9'h0B1, 9'h010, 9'h004, 9'h155};
    check_stream("backpressure", base);

    // Full frame wrap: 8 bytes over 2 pages of 4 columns, then one more
    cpu_own();
    base = cap.size();
    fd_base = fd_count;
    @(negedge clk);
    dma_if.chipselect = 1'b1;
    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_idle("frame");
    repeat (2) @(posedge clk);
    #1;
    chk("frame_done pulses", 32'(fd_count - fd_base), 32'h1);
    exp_q = {9'h0B0, 9'h010, 9'h004, 9'h101, 9'h102, 9'h103, 9'h104,
             9'h0B1, 9'h010, 9'h004, 9'h105, 9'h106, 9'h107, 9'h108};
    check_stream("frame", base);
    base = cap.size();
    push(8'h09);
    wait_idle("frame next");
    exp_q = {9'h0B0, 9'h010, 9'h004, 9'h109};
    check_stream("after wrap", base);
    chk("frame_done after wrap byte", 32'(fd_count - fd_base), 32'h1);

    // Frame restart after two bytes of page 0
    cpu_own();
    @(negedge clk);
    dma_if.chipselect = 1'b1;
    push(8'hA1);
    push(8'hA2);
    wait_idle("restart pre");
    base = cap.size();
    @(negedge clk);
    frame_restart = 1'b1;
    @(negedge clk);
    frame_restart = 1'b0;
    push(8'hA3);
    wait_idle("restart");
    exp_q = {9'h0B0, 9'h010, 9'h004, 9'h1A3};
    check_stream("restart", base);

    // Asynchronous reset during a strobe-high phase with a full FIFO
    cpu_own();
    mon_en = 1'b0;
    @(negedge clk);
    dma_if.chipselect = 1'b1;
    push(8'hC1);
    push(8'hC2);
    push(8'hC3);
    push(8'hC4);
    chk("pre-reset waitrequest", 32'(dma_if.waitrequest), 32'h1);
    chk("pre-reset strobe high", 32'(lcd_ctrl[4]), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("async reset ctrl", 32'(lcd_ctrl), 32'h03);
    chk("async reset data", 32'(lcd_data), 32'h00);
    chk("async reset waitrequest", 32'(dma_if.waitrequest), 32'h0);
    chk("async reset busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    dma_if.chipselect = 1'b0;
    @(posedge clk); #1;
    chk("post-reset cpu ctrl", 32'(lcd_ctrl), 32'h0A);
    chk("post-reset busy", 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
